// File: rtl/acc_stream.sv
// Streaming packet accumulator: sums the beats of each packet and holds the
// sum, sticky overflow and saturating beat count until downstream takes it.

module adder_flex #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
endmodule

module acc_stream #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 10,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_last,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_ovf,
    output logic [CNT_WIDTH-1:0] o_count
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                 state, state_nxt;
    logic [ACC_WIDTH-1:0]   acc, add_sum, data_ext;
    logic [CNT_WIDTH-1:0]   cnt;
    logic                   ovf, add_cout, beat;

    assign data_ext = ACC_WIDTH'(i_data);
    // Gate with reset so the source sees not-ready while the block is held.
    assign o_ready  = i_rst_n && (state != OUT);
    assign beat     = i_valid && o_ready;

    adder_flex #(.W(ACC_WIDTH)) u_add (
        .i_a    (acc),
        .i_b    (data_ext),
        .i_cin  (1'b0),
        .o_sum  (add_sum),
        .o_cout (add_cout)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACC: if (beat) state_nxt = i_last ? OUT : ACC;
            OUT:       if (i_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc <= '0;
            cnt <= '0;
            ovf <= 1'b0;
        end else if (beat) begin
            if (state == IDLE) begin
                acc <= data_ext;
                cnt <= CNT_WIDTH'(1);
                ovf <= 1'b0;
            end else begin
                acc <= add_sum;
                ovf <= ovf | add_cout;
                if (cnt != {CNT_WIDTH{1'b1}}) cnt <= cnt + 1'b1;
            end
        end
    end

    assign o_valid = (state == OUT);
    assign o_sum   = acc;
    assign o_ovf   = ovf;
    assign o_count = cnt;
endmodule

// File: tb/tb_acc_stream.sv
// Scoreboard bench for acc_stream: stimulus pushes expected results, a monitor
// pops and compares them on every output handshake.
module tb_acc_stream;
    logic       i_clk, i_rst_n, i_valid, o_ready, i_last, o_valid, i_ready, o_ovf;
    logic [7:0] i_data;
    logic [9:0] o_sum;
    logic [3:0] o_count;

    typedef struct {
        logic [9:0] sum;
        logic       ovf;
        logic [3:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   rnd_rdy = 0;

    acc_stream dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_sum   (o_sum),
        .o_ovf   (o_ovf),
        .o_count (o_count)
    );

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [9:0] s, input logic o, input logic [3:0] c);
        exp_t e;
        e.sum = s; e.ovf = o; e.cnt = c;
        sb.push_back(e);
    endtask

    // Present one beat and hold it until accepted; returns at posedge+1.
    task automatic beat(input logic [7:0] d, input logic l);
        bit ok;
        ok = 0;
        i_valid = 1; i_data = d; i_last = l;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge i_clk);
            ok = o_ready;
            @(posedge i_clk);
            #1;
        end
        i_valid = 0;
        i_data  = 8'($urandom);
        i_last  = 1'($urandom);
        if (!ok) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got no acceptance expected o_ready within 1000 cycles");
        end
    endtask

    task automatic pkt_const(input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) beat(v, i == n - 1);
    endtask

    // Random downstream back-pressure.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (rnd_rdy) i_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: every presented-and-taken result must match the oldest expected.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got sum=0x%0h expected no output", o_sum);
                end else begin
                    e = sb.pop_front();
                    chk("sum",   32'(o_sum),   32'(e.sum));
                    chk("ovf",   32'(o_ovf),   32'(e.ovf));
                    chk("count", 32'(o_count), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        int total, n;
        logic [7:0] d;
        i_rst_n = 0; i_valid = 0; i_data = 0; i_last = 0; i_ready = 1;
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_sum",   32'(o_sum),   0);
        chk("rst_ovf",   32'(o_ovf),   0);
        chk("rst_count", 32'(o_count), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1;

        // 0x10+0x20+0x30: result one cycle after last, gone the cycle after
        beat(8'h10, 0);
        beat(8'h20, 0);
        push(10'h060, 0, 4'd3);
        beat(8'h30, 1);
        chk("latency_valid", 32'(o_valid), 1);
        @(posedge i_clk); #1;
        chk("valid_drop", 32'(o_valid), 0);

        push(10'h0FB, 1, 4'd5);  pkt_const(5, 8'hFF);
        push(10'h3FC, 0, 4'd4);  pkt_const(4, 8'hFF);
        push(10'h014, 0, 4'd15); pkt_const(20, 8'h01);

        // Single beat held under back-pressure
        @(posedge i_clk); #1;
        i_ready = 0;
        beat(8'hAB, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(o_valid), 1);
            chk("hold_ready", 32'(o_ready), 0);
            chk("hold_sum",   32'(o_sum),   32'h0AB);
            chk("hold_count", 32'(o_count), 1);
        end
        push(10'h0AB, 0, 4'd1);
        @(posedge i_clk); #1;
        i_ready = 1;
        @(posedge i_clk); #1;
        chk("after_hs_valid", 32'(o_valid), 0);
        chk("after_hs_ready", 32'(o_ready), 1);

        // Reset mid-packet discards the partial sum
        beat(8'h01, 0);
        beat(8'h02, 0);
        i_rst_n = 0;
        @(negedge i_clk);
        chk("midrst_ready", 32'(o_ready), 0);
        chk("midrst_sum",   32'(o_sum),   0);
        chk("midrst_count", 32'(o_count), 0);
        @(posedge i_clk); #1;
        i_rst_n = 1;
        push(10'h005, 0, 4'd1);
        beat(8'h05, 1);

        // Random packets with gaps and random back-pressure
        rnd_rdy = 1;
        for (int p = 0; p < 1000; p++) begin
            n = $urandom_range(1, 20);
            total = 0;
            for (int i = 0; i < n; i++) begin
                d = 8'($urandom);
                total += d;
                if (i == n - 1) push(10'(total), total > 1023, (n > 15) ? 4'd15 : 4'(n));
                beat(d, i == n - 1);
                repeat ($urandom_range(0, 2)) @(posedge i_clk);
                #1;
            end
        end
        rnd_rdy = 0;
        @(posedge i_clk); #1;
        i_ready = 1;
        for (int t = 0; t < 200 && sb.size() != 0; t++) @(posedge i_clk);
        #1;
        chk("drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
